data_bus_arbiter: RTL and testbench
===================================

// Module: data_bus_arbiter
// PURPOSE
//  Shares the single data-side Bridge port (Bus_addr/Bus_wdata/Bus_wen/Bus_rdata) between two masters:
//  M0 = CPU MEM stage, M1 = DMA/loader engine. Registers the bus outputs, sequences reads against a
//  synchronous slave with RD_LAT cycles of latency, and raises cpu_stall while M0 is waiting.
//  Sits between myCPU's Bus_* port and the Bridge.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width
//  RD_LAT      1   cycles from the bus address cycle to valid Bus_rdata; legal range 0..7
//  STARVE_MAX  4   consecutive M0 grants while M1 waits before M1 is forced; legal range 1..15
// PORTS
//  cpu_clk     in   1       clock, rising edge
//  cpu_rst     in   1       reset, asynchronous, active-low
//  m0_req      in   1       CPU request; held with addr/wen/wdata stable until m0_ack
//  m0_addr     in   ADDR_W  CPU address
//  m0_wen      in   1       1 = write, 0 = read
//  m0_wdata    in   DATA_W  CPU write data
//  m0_rdata    out  DATA_W  read data; valid only while m0_ack=1
//  m0_ack      out  1       one-cycle completion pulse
//  m1_req/m1_addr/m1_wen/m1_wdata/m1_rdata/m1_ack  same as the M0 signals, for the DMA master
//  cpu_stall   out  1       m0_req & ~m0_ack (combinational); freezes the CPU pipeline
//  Bus_addr    out  ADDR_W  registered bus address
//  Bus_wen     out  1       registered bus write strobe
//  Bus_wdata   out  DATA_W  registered bus write data
//  Bus_rdata   in   DATA_W  slave read data
// BEHAVIOUR
//  Reset (cpu_rst=0, asynchronous):
//   - state=IDLE, starve_cnt=0.
//   - Bus_addr=0, Bus_wen=0, Bus_wdata=0, m0_ack=0, m1_ack=0, m*_rdata=0.
//   - Any in-flight transaction is dropped with no ack.
//  FSM states: IDLE, ADDR, RWAIT.
//   IDLE: if any req is high, pick a winner, latch its addr/wen/wdata into the Bus_* registers, go to ADDR.
//    - If no req is high, Bus_* outputs are 0.
//   ADDR (one cycle; bus shows the winner's transaction):
//    - Write: Bus_wen=1 for exactly this cycle; winner ack=1 this cycle; next state IDLE.
//    - Read, RD_LAT=0: ack=1 this cycle; m*_rdata=Bus_rdata; next state IDLE.
//    - Read, RD_LAT>0: Bus_wen=0; load lat_cnt=RD_LAT-1; next state RWAIT.
//   RWAIT: hold Bus_addr; when lat_cnt==0, winner ack=1 and m*_rdata=Bus_rdata; next state IDLE.
//    - Otherwise decrement lat_cnt.
//  Latency: a write is acked 1 cycle after req is sampled in IDLE; a read 1+RD_LAT cycles after.
//   Minimum issue interval is 2 cycles (the ack cycle is followed by IDLE).
//  Arbitration (IDLE only):
//   - Only M0 requests: M0 wins. Only M1 requests: M1 wins.
//   - Both request: M0 wins unless starve_cnt==STARVE_MAX, in which case M1 wins.
//  starve_cnt:
//   - +1 when M0 wins while m1_req=1.
//   - Cleared when M1 wins or when m1_req=0 in IDLE.
//   - Saturates at STARVE_MAX.
//  The non-granted master sees ack=0 and rdata=0. Acks are never high for both masters in one cycle.
//  A req that drops before its ack is a protocol violation. The arbiter still completes the bus cycle
//   and suppresses the ack.
//  The arbiter never reorders a master's own transactions. A master presenting a new req in the cycle
//   after its ack is arbitrated in that IDLE cycle.
// TESTING
//  1 Reset: assert cpu_rst=0 during RWAIT -> Bus_wen=0 and both acks=0 immediately; IDLE after release; no ack.
//  2 M0 write addr=0x10, wdata=0xDEADBEEF from cycle 0 -> cycle 1: Bus_wen=1, Bus_addr=0x10,
//    Bus_wdata=0xDEADBEEF, m0_ack=1; cpu_stall=1 in cycle 0 only.
//  3 RD_LAT=1, M1 read addr=0x20, slave returns 0x12345678 -> m1_ack=1 at cycle 2, m1_rdata=0x12345678;
//    Bus_addr held 0x20 for cycles 1-2.
//  4 STARVE_MAX=2, both masters requesting continuously -> grant order M0,M0,M1,M0,M0,M1.
//  5 M1 alone, then M0 arrives while M1 is in RWAIT -> M1 completes first; M0 granted in the next IDLE;
//    starve_cnt stays 0.
//  6 RD_LAT=0, M0 write 0x55 to addr 0x8 then read addr 0x8 -> read acks with m0_rdata=0x55, 2 cycles after the write ack.

Source files
------------

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter for the data-side bridge port.
// CPU (M0) normally wins; DMA (M1) is forced after STARVE_MAX losses.
module data_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_wen,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_wen,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] Bus_addr,
  output logic              Bus_wen,
  output logic [DATA_W-1:0] Bus_wdata,
  input  logic [DATA_W-1:0] Bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RWAIT
  } state_t;

  localparam int LAT_M1 = (RD_LAT > 0) ? RD_LAT - 1 : 0;
  localparam logic [3:0] SMAX = STARVE_MAX[3:0];

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic [2:0]        lat_q, lat_d;
  logic [3:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              pick_m1;
  logic              done;

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      lat_q    <= '0;
      starve_q <= '0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    lat_d    = lat_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    pick_m1  = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        addr_d  = '0;
        wen_d   = 1'b0;
        wdata_d = '0;
        pick_m1 = m1_req & (~m0_req | (starve_q == SMAX));
        if (m0_req | m1_req) begin
          grant_d = pick_m1;
          addr_d  = pick_m1 ? m1_addr : m0_addr;
          wen_d   = pick_m1 ? m1_wen : m0_wen;
          wdata_d = pick_m1 ? m1_wdata : m0_wdata;
          state_d = ADDR;
        end
        if (!m1_req || pick_m1) begin
          starve_d = '0;
        end else if (starve_q != SMAX) begin
          starve_d = starve_q + 4'd1;
        end
      end
      ADDR: begin
        if (wen_q || RD_LAT == 0) begin
          done    = 1'b1;
          state_d = IDLE;
          addr_d  = '0;
          wen_d   = 1'b0;
          wdata_d = '0;
        end else begin
          lat_d   = LAT_M1[2:0];
          state_d = RWAIT;
        end
      end
      RWAIT: begin
        if (lat_q == 3'd0) begin
          done    = 1'b1;
          state_d = IDLE;
          addr_d  = '0;
          wdata_d = '0;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A master that dropped its req early still gets its bus cycle, but no ack.
  assign m0_ack    = done & ~grant_q & m0_req;
  assign m1_ack    = done & grant_q & m1_req;
  assign m0_rdata  = m0_ack ? Bus_rdata : '0;
  assign m1_rdata  = m1_ack ? Bus_rdata : '0;
  assign cpu_stall = m0_req & ~m0_ack;
  assign Bus_addr  = addr_q;
  assign Bus_wen   = wen_q;
  assign Bus_wdata = wdata_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter.
// Two instances: RD_LAT=1/STARVE_MAX=2 and RD_LAT=0/STARVE_MAX=4.
module tb_data_bus_arbiter;

  logic        clk;
  logic        rst_n;
  int          tests;
  int          failed;

  logic        a_m0_req, a_m0_wen, a_m1_req, a_m1_wen;
  logic [31:0] a_m0_addr, a_m0_wdata, a_m1_addr, a_m1_wdata;
  logic [31:0] a_m0_rdata, a_m1_rdata;
  logic        a_m0_ack, a_m1_ack, a_stall;
  logic [31:0] a_bus_addr, a_bus_wdata, a_bus_rdata;
  logic        a_bus_wen;

  logic        b_m0_req, b_m0_wen, b_m1_req, b_m1_wen;
  logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic        b_m0_ack, b_m1_ack, b_stall;
  logic [31:0] b_bus_addr, b_bus_wdata, b_bus_rdata;
  logic        b_bus_wen;
  logic [31:0] mem [16];

  data_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .RD_LAT(1), .STARVE_MAX(2)
  ) u_dut (
    .cpu_clk(clk), .cpu_rst(rst_n),
    .m0_req(a_m0_req), .m0_addr(a_m0_addr), .m0_wen(a_m0_wen),
    .m0_wdata(a_m0_wdata), .m0_rdata(a_m0_rdata), .m0_ack(a_m0_ack),
    .m1_req(a_m1_req), .m1_addr(a_m1_addr), .m1_wen(a_m1_wen),
    .m1_wdata(a_m1_wdata), .m1_rdata(a_m1_rdata), .m1_ack(a_m1_ack),
    .cpu_stall(a_stall),
    .Bus_addr(a_bus_addr), .Bus_wen(a_bus_wen),
    .Bus_wdata(a_bus_wdata), .Bus_rdata(a_bus_rdata)
  );

  data_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .RD_LAT(0), .STARVE_MAX(4)
  ) u_dut0 (
    .cpu_clk(clk), .cpu_rst(rst_n),
    .m0_req(b_m0_req), .m0_addr(b_m0_addr), .m0_wen(b_m0_wen),
    .m0_wdata(b_m0_wdata), .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack),
    .m1_req(b_m1_req), .m1_addr(b_m1_addr), .m1_wen(b_m1_wen),
    .m1_wdata(b_m1_wdata), .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack),
    .cpu_stall(b_stall),
    .Bus_addr(b_bus_addr), .Bus_wen(b_bus_wen),
    .Bus_wdata(b_bus_wdata), .Bus_rdata(b_bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // zero-latency slave memory for the RD_LAT=0 instance
  always @(posedge clk) begin
    if (b_bus_wen) mem[b_bus_addr[3:0]] <= b_bus_wdata;
  end
  assign b_bus_rdata = mem[b_bus_addr[3:0]];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_g [6];
    tests  = 0;
    failed = 0;
    exp_g  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst_n = 1'b0;
    a_m0_req = 0; a_m0_wen = 0; a_m0_addr = 0; a_m0_wdata = 0;
    a_m1_req = 0; a_m1_wen = 0; a_m1_addr = 0; a_m1_wdata = 0;
    b_m0_req = 0; b_m0_wen = 0; b_m0_addr = 0; b_m0_wdata = 0;
    b_m1_req = 0; b_m1_wen = 0; b_m1_addr = 0; b_m1_wdata = 0;
    a_bus_rdata = 32'h1234_5678;

    tick();
    tick();
    chk("rst_bus_addr", a_bus_addr, 32'h0);
    chk("rst_bus_wen", {31'b0, a_bus_wen}, 32'h0);
    chk("rst_acks", {30'b0, a_m0_ack, a_m1_ack}, 32'h0);
    chk("rst_b_bus_wdata", b_bus_wdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // reset asserted in the middle of an M1 read
    a_m1_req = 1; a_m1_wen = 0; a_m1_addr = 32'h40;
    tick();
    chk("rr_addr_c1", a_bus_addr, 32'h40);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rr_bus_wen", {31'b0, a_bus_wen}, 32'h0);
    chk("rr_acks", {30'b0, a_m0_ack, a_m1_ack}, 32'h0);
    chk("rr_bus_addr", a_bus_addr, 32'h0);
    a_m1_req = 0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rr_idle_ack", {31'b0, a_m1_ack}, 32'h0);
    chk("rr_idle_addr", a_bus_addr, 32'h0);

    // M0 write
    a_m0_req = 1; a_m0_wen = 1; a_m0_addr = 32'h10;
    a_m0_wdata = 32'hDEAD_BEEF;
    #1;
    chk("wr_stall_c0", {31'b0, a_stall}, 32'h1);
    chk("wr_ack_c0", {31'b0, a_m0_ack}, 32'h0);
    tick();
    chk("wr_bus_wen", {31'b0, a_bus_wen}, 32'h1);
    chk("wr_bus_addr", a_bus_addr, 32'h10);
    chk("wr_bus_wdata", a_bus_wdata, 32'hDEAD_BEEF);
    chk("wr_ack", {31'b0, a_m0_ack}, 32'h1);
    chk("wr_stall_c1", {31'b0, a_stall}, 32'h0);
    chk("wr_m1_ack", {31'b0, a_m1_ack}, 32'h0);
    a_m0_req = 0;
    tick();
    chk("wr_idle_wen", {31'b0, a_bus_wen}, 32'h0);
    chk("wr_idle_addr", a_bus_addr, 32'h0);

    // M1 read, RD_LAT=1
    a_m1_req = 1; a_m1_wen = 0; a_m1_addr = 32'h20;
    tick();
    chk("rd_addr_c1", a_bus_addr, 32'h20);
    chk("rd_ack_c1", {31'b0, a_m1_ack}, 32'h0);
    chk("rd_wen_c1", {31'b0, a_bus_wen}, 32'h0);
    tick();
    chk("rd_addr_c2", a_bus_addr, 32'h20);
    chk("rd_ack_c2", {31'b0, a_m1_ack}, 32'h1);
    chk("rd_rdata", a_m1_rdata, 32'h1234_5678);
    chk("rd_m0_rdata", a_m0_rdata, 32'h0);
    a_m1_req = 0;
    tick();
    chk("rd_idle_ack", {31'b0, a_m1_ack}, 32'h0);

    // starvation: both masters writing continuously
    a_m0_req = 1; a_m0_wen = 1; a_m0_addr = 32'h100; a_m0_wdata = 32'hA0;
    a_m1_req = 1; a_m1_wen = 1; a_m1_addr = 32'h200; a_m1_wdata = 32'hB1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("sv_m0_ack%0d", i), {31'b0, a_m0_ack},
          {31'b0, ~exp_g[i]});
      chk($sformatf("sv_m1_ack%0d", i), {31'b0, a_m1_ack},
          {31'b0, exp_g[i]});
      chk($sformatf("sv_addr%0d", i), a_bus_addr,
          exp_g[i] ? 32'h200 : 32'h100);
      if (i == 5) begin
        a_m0_req = 0;
        a_m1_req = 0;
      end
      tick();
    end

    // M0 arrives while M1 waits on its read
    a_m1_req = 1; a_m1_wen = 0; a_m1_addr = 32'h24;
    tick();
    a_m0_req = 1; a_m0_wen = 1; a_m0_addr = 32'h30; a_m0_wdata = 32'h77;
    #1;
    chk("ov_stall", {31'b0, a_stall}, 32'h1);
    tick();
    chk("ov_m1_ack", {31'b0, a_m1_ack}, 32'h1);
    chk("ov_m0_ack", {31'b0, a_m0_ack}, 32'h0);
    a_m1_req = 0;
    tick();
    chk("ov_idle_m0", {31'b0, a_m0_ack}, 32'h0);
    tick();
    chk("ov_m0_late", {31'b0, a_m0_ack}, 32'h1);
    chk("ov_m0_addr", a_bus_addr, 32'h30);
    a_m0_req = 0;
    tick();

    // RD_LAT=0: write then read back through the slave memory
    b_m0_req = 1; b_m0_wen = 1; b_m0_addr = 32'h8; b_m0_wdata = 32'h55;
    tick();
    chk("z_wr_ack", {31'b0, b_m0_ack}, 32'h1);
    chk("z_wr_wen", {31'b0, b_bus_wen}, 32'h1);
    b_m0_wen = 0; b_m0_wdata = 0;
    tick();
    chk("z_idle_ack", {31'b0, b_m0_ack}, 32'h0);
    chk("z_idle_stall", {31'b0, b_stall}, 32'h1);
    tick();
    chk("z_rd_ack", {31'b0, b_m0_ack}, 32'h1);
    chk("z_rd_rdata", b_m0_rdata, 32'h55);
    chk("z_rd_wen", {31'b0, b_bus_wen}, 32'h0);
    b_m0_req = 0;
    tick();
    chk("z_end_ack", {31'b0, b_m0_ack}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
